// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch definitions: register width, the canonical NOP and the
// queue entry layout.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with a synchronous flush and an occupancy count output.
// DEPTH must be a power of two so that the read and write pointers wrap naturally.
module fifo_sync
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       push,
  input  entry_t                     wdata,
  input  logic                       pop,
  output entry_t                     rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues word-aligned memory requests, queues the
// in-order responses with their PCs and handles redirects by discarding
// responses that are still in flight. Defining FETCH_QUEUE_PERF_EN adds
// perf_empty_cnt_o, a count of cycles in which decode was ready but starved.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h8000_0000,
  parameter int unsigned     DEPTH     = 4,
  parameter int unsigned     MAX_OUTST = 2
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  input  logic            instr_ready_i
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]     perf_empty_cnt_o
`endif
);

  localparam int unsigned OW = $clog2(MAX_OUTST+1);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] target_pc;
  logic [OW-1:0]   outst;
  logic [OW-1:0]   discard;
  logic [CW-1:0]   count;
  logic            empty;
  logic            gnt;
  logic            rsp;
  logic            push;
  logic            pop;
  logic            unused_pc_bits;
  fetch_entry_t    head;
  fetch_entry_t    wentry;

  assign target_pc      = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc_i[1:0];

  // Queue slots are reserved at request time, so a response can always be pushed.
  assign imem_req_o  = rstn_i & ~redirect_i
                     & (32'(outst) < MAX_OUTST)
                     & ((32'(count) + 32'(outst)) < DEPTH);
  assign imem_addr_o = fetch_pc;

  assign gnt  = imem_req_o & imem_gnt_i;
  assign rsp  = imem_rvalid_i & (outst != '0);
  assign push = rsp & (discard == '0) & ~redirect_i;

  assign instr_valid_o = ~empty & ~redirect_i;
  assign pop           = instr_valid_o & instr_ready_i;
  assign instr_o       = empty ? NOP : head.instr;
  assign pc_o          = empty ? resp_pc : head.pc;

  assign wentry.pc    = resp_pc;
  assign wentry.instr = imem_rdata_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      outst    <= '0;
      discard  <= '0;
    end else begin
      outst <= outst + OW'(gnt) - OW'(rsp);
      if (redirect_i) begin
        // Everything still in flight (older discards included) becomes stale.
        fetch_pc <= target_pc;
        resp_pc  <= target_pc;
        discard  <= outst - OW'(rsp);
      end else begin
        if (gnt)  fetch_pc <= fetch_pc + XLEN'(4);
        if (push) resp_pc  <= resp_pc + XLEN'(4);
        if (rsp && (discard != '0)) discard <= discard - 1'b1;
      end
    end
  end

  fifo_sync #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk   (clk_i),
    .rstn  (rstn_i),
    .flush (redirect_i),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .count (count)
  );

`ifdef FETCH_QUEUE_PERF_EN
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      perf_empty_cnt_o <= '0;
    end else if (instr_ready_i && !instr_valid_o) begin
      perf_empty_cnt_o <= perf_empty_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order, fixed-latency memory model.
// With FETCH_QUEUE_PERF_EN defined the starvation counter is also checked.
module tb_fetch_queue;
  import riscv_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i = 1'b0;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_empty_cnt_o;
`endif

  always #5 clk = ~clk;

  fetch_queue #(
    .RESET_PC  (RST_PC),
    .DEPTH     (4),
    .MAX_OUTST (2)
  ) dut (
    .clk_i         (clk),
    .rstn_i        (rstn_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_ready_i (instr_ready_i)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .perf_empty_cnt_o (perf_empty_cnt_o)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } req_t;

  req_t        pend[$];
  int unsigned passed = 0;
  int unsigned total = 0;
  int unsigned lat = 1;
  int unsigned cyc = 0;
  logic        gnt_en = 1'b1;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc, s_perf;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hFFFF_0000;
  endfunction

  // One clock cycle: drive memory inputs at the negedge, sample 2 units later,
  // update the memory model, then wait for the next negedge.
  task automatic cycle();
    imem_gnt_i = gnt_en;
    if (rstn_i && pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hDEAD_BEEF;
    end
    #2;
    s_req = imem_req_o; s_addr = imem_addr_o; s_valid = instr_valid_o;
    s_instr = instr_o; s_pc = pc_o;
`ifdef FETCH_QUEUE_PERF_EN
    s_perf = perf_empty_cnt_o;
`else
    s_perf = '0;
`endif
    if (!rstn_i) begin
      pend.delete();
    end else begin
      if (imem_rvalid_i) void'(pend.pop_front());
      if (imem_req_o && imem_gnt_i) pend.push_back('{addr: imem_addr_o, due: cyc + lat});
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rstn_i = 1'b0; redirect_i = 1'b0; instr_ready_i = 1'b0; gnt_en = 1'b1;
    repeat (2) cycle();
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; redirect_i = 1'b0; instr_ready_i = 1'b1; gnt_en = 1'b1;
    repeat (2) cycle();
    total++; if (s_req !== 1'b0) $display("FAIL reset_req: got %b want 0", s_req); else passed++;
    total++; if (s_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", s_valid); else passed++;
    total++; if (s_instr !== 32'h0000_0013) $display("FAIL reset_instr: got %h want 00000013", s_instr); else passed++;
    total++; if (s_pc !== RST_PC) $display("FAIL reset_pc: got %h want %h", s_pc, RST_PC); else passed++;
`ifdef FETCH_QUEUE_PERF_EN
    total++; if (s_perf !== 32'd0) $display("FAIL reset_perf: got %0d want 0", s_perf); else passed++;
`endif
    rstn_i = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset(); lat = 1; instr_ready_i = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      total++;
      if (s_req !== 1'b1 || s_addr !== RST_PC + 32'(4 * (i - 1)))
        $display("FAIL stream_addr c%0d: got req=%b addr=%h want req=1 addr=%h", i, s_req, s_addr, RST_PC + 32'(4 * (i - 1)));
      else passed++;
      total++;
      if (s_valid !== (i >= 3)) $display("FAIL stream_valid c%0d: got %b want %b", i, s_valid, (i >= 3));
      else passed++;
      if (i >= 3) begin
        exp_pc = RST_PC + 32'(4 * (i - 3));
        total++;
        if (s_pc !== exp_pc || s_instr !== mem_word(exp_pc))
          $display("FAIL stream_head c%0d: got pc=%h instr=%h want pc=%h instr=%h", i, s_pc, s_instr, exp_pc, mem_word(exp_pc));
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    int unsigned grants = 0;
    int unsigned pops = 0;
    do_reset(); lat = 1; instr_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_req) grants++;
    end
    total++; if (grants != 4) $display("FAIL bp_grants: got %0d want 4", grants); else passed++;
    total++; if (s_req !== 1'b0) $display("FAIL bp_req_full: got %b want 0", s_req); else passed++;
    instr_ready_i = 1'b1;
    for (int i = 0; i < 20 && pops < 4; i++) begin
      cycle();
      if (s_valid) begin
        total++;
        if (s_pc !== RST_PC + 32'(4 * pops))
          $display("FAIL bp_pop_pc%0d: got %h want %h", pops, s_pc, RST_PC + 32'(4 * pops));
        else passed++;
        pops++;
      end
    end
    total++; if (pops != 4) $display("FAIL bp_pop_count: got %0d want 4", pops); else passed++;
  endtask

  // Redirect(s) issued with two requests in flight at latency 3.
  task automatic run_redirect(input string name, input logic [31:0] t1,
                              input logic two, input logic [31:0] t2, input logic [31:0] want);
    logic        seen_req = 1'b0;
    logic        seen_valid = 1'b0;
    logic [31:0] first_addr = '0;
    logic [31:0] first_pc = '0;
    logic [31:0] first_instr = '0;
    do_reset(); lat = 3; instr_ready_i = 1'b1;
    repeat (2) cycle();
    redirect_i = 1'b1; redirect_pc_i = t1;
    cycle();
    total++; if (s_req !== 1'b0 || s_valid !== 1'b0)
      $display("FAIL %s_during: got req=%b valid=%b want 0 0", name, s_req, s_valid); else passed++;
    if (two) begin
      redirect_pc_i = t2;
      cycle();
    end
    redirect_i = 1'b0;
    for (int i = 0; i < 20 && !seen_valid; i++) begin
      cycle();
      if (s_req && !seen_req) begin seen_req = 1'b1; first_addr = s_addr; end
      if (s_valid) begin seen_valid = 1'b1; first_pc = s_pc; first_instr = s_instr; end
    end
    total++; if (!seen_req || first_addr !== want)
      $display("FAIL %s_addr: got seen=%b addr=%h want %h", name, seen_req, first_addr, want); else passed++;
    total++; if (!seen_valid || first_pc !== want)
      $display("FAIL %s_pc: got seen=%b pc=%h want %h", name, seen_valid, first_pc, want); else passed++;
    total++; if (first_instr !== mem_word(want))
      $display("FAIL %s_instr: got %h want %h", name, first_instr, mem_word(want)); else passed++;
  endtask

  task automatic test_redirect();
    run_redirect("redir", 32'h8000_0102, 1'b0, '0, 32'h8000_0100);
  endtask

  task automatic test_double_redirect();
    run_redirect("redir2", 32'h8000_0102, 1'b1, 32'h8000_0300, 32'h8000_0300);
  endtask

  task automatic test_gnt_stall();
    do_reset(); lat = 1; instr_ready_i = 1'b1; gnt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++; if (s_req !== 1'b1 || s_addr !== RST_PC)
        $display("FAIL stall_hold%0d: got req=%b addr=%h want 1 %h", i, s_req, s_addr, RST_PC); else passed++;
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0040;
    cycle();
    total++; if (s_req !== 1'b0) $display("FAIL stall_withdraw: got %b want 0", s_req); else passed++;
    redirect_i = 1'b0; gnt_en = 1'b1;
    cycle();
    total++; if (s_req !== 1'b1 || s_addr !== 32'h8000_0040)
      $display("FAIL stall_newaddr: got req=%b addr=%h want 1 80000040", s_req, s_addr); else passed++;
    repeat (2) cycle();
    total++; if (s_valid !== 1'b1 || s_pc !== 32'h8000_0040)
      $display("FAIL stall_first: got valid=%b pc=%h want 1 80000040", s_valid, s_pc); else passed++;
  endtask

  task automatic test_redirect_pop();
    do_reset(); lat = 1; instr_ready_i = 1'b1;
    repeat (4) cycle();
    total++; if (s_valid !== 1'b1) $display("FAIL rpop_pre_valid: got %b want 1", s_valid); else passed++;
    redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200;
    cycle();
    total++; if (s_valid !== 1'b0) $display("FAIL rpop_suppress: got %b want 0", s_valid); else passed++;
    redirect_i = 1'b0;
    cycle();
    total++; if (s_valid !== 1'b0) $display("FAIL rpop_empty: got %b want 0", s_valid); else passed++;
    total++; if (s_req !== 1'b1 || s_addr !== 32'h8000_0200)
      $display("FAIL rpop_addr: got req=%b addr=%h want 1 80000200", s_req, s_addr); else passed++;
    repeat (2) cycle();
    total++; if (s_valid !== 1'b1 || s_pc !== 32'h8000_0200)
      $display("FAIL rpop_first: got valid=%b pc=%h want 1 80000200", s_valid, s_pc); else passed++;
  endtask

  // Latency 5 with two in flight gives valid pairs every 6 cycles from cycle 7.
  task automatic test_latency5();
    logic        exp_valid;
    int unsigned empties = 0;
    do_reset(); lat = 5; instr_ready_i = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      cycle();
      exp_valid = (c >= 7) && (((c - 7) % 6) < 2);
      if (!exp_valid) empties++;
      total++; if (s_valid !== exp_valid)
        $display("FAIL lat5_valid c%0d: got %b want %b", c, s_valid, exp_valid); else passed++;
    end
    cycle();
`ifdef FETCH_QUEUE_PERF_EN
    total++; if (s_perf !== 32'(empties))
      $display("FAIL perf_empty: got %0d want %0d", s_perf, empties); else passed++;
`else
    if (s_perf !== 32'(empties)) begin end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_double_redirect();
    test_gnt_stall();
    test_redirect_pop();
    test_latency5();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameters SHALL be: RESET_PC, default 32'h8000_0000, first fetch address; DEPTH, default 4, queue entries (power of 2, >=2); MAX_OUTST, default 2, max in-flight memory requests (1..DEPTH).
REQ-002 Ports SHALL be, in order:
- clk_i  in  1  single clock
- rstn_i  in  1  reset: one clock; reset is synchronous and active-low
- redirect_i  in  1  branch/jump redirect, flushes fetch
- redirect_pc_i  in  XLEN  redirect target
- imem_req_o  out  1  memory request valid
- imem_addr_o  out  XLEN  request address, word aligned
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid
- imem_rdata_i  in  XLEN  response instruction
- instr_valid_o  out  1  queue head valid to decode
- instr_o  out  XLEN  head instruction
- pc_o  out  XLEN  head PC
- instr_ready_i  in  1  decode accepts head (replaces stall)

Function
REQ-003 Memory protocol SHALL be: request accepted when imem_req_o & imem_gnt_i; responses in order, at least 1 cycle after grant.
REQ-004 imem_req_o SHALL assert when outstanding < MAX_OUTST and occupancy + outstanding < DEPTH and redirect_i = 0.
REQ-005 imem_addr_o SHALL hold stable while imem_req_o = 1 and imem_gnt_i = 0; on grant, fetch PC SHALL advance by 4 (wraps modulo 2^XLEN).
REQ-006 A non-discarded response SHALL be pushed with {pc, rdata}; pc comes from a response-PC register advanced by 4 per push.
REQ-007 Latency: grant at t, rvalid at t+k -> instr_valid_o at t+k+1 (no bypass).
REQ-008 instr_valid_o SHALL be (queue not empty) & ~redirect_i; pop on instr_valid_o & instr_ready_i.
REQ-009 On redirect_i: queue flushed next cycle; fetch PC and response PC load {redirect_pc_i[XLEN-1:2], 2'b00}; discard counter loads outstanding count (minus any response arriving this cycle, which is dropped); the ungranted request is withdrawn (imem_req_o = 0 this cycle).
REQ-010 While the discard counter is nonzero, each rvalid SHALL decrement it and be dropped, not pushed.
REQ-011 Outstanding counter SHALL handle simultaneous grant and rvalid (net 0); width $clog2(MAX_OUTST+1).
REQ-012 rvalid with outstanding = 0 SHALL be ignored.
REQ-013 Simultaneous push and pop SHALL keep occupancy unchanged; push never occurs when full (guaranteed by REQ-004).
REQ-014 Redirect on consecutive cycles: last one wins; discard count accumulates correctly.

Reset
REQ-015 When rstn_i = 0 at a clock edge: queue empty, outstanding = 0, discard = 0, fetch PC = response PC = RESET_PC, imem_req_o = 0, instr_valid_o = 0, instr_o = 32'h0000_0013, pc_o = RESET_PC.
REQ-016 Reset mid-transaction SHALL drop all in-flight responses (memory resets with the core); first request, at RESET_PC, in first cycle after release.

Configuration
REQ-017 Macro FETCH_QUEUE_PERF_EN SHALL, when defined, add output perf_empty_cnt_o (32 bits, wraps) counting cycles with instr_ready_i = 1 and instr_valid_o = 0, reset to 0.
REQ-018 Without FETCH_QUEUE_PERF_EN the port and counter SHALL not exist; all other behaviour is identical.

Structure
REQ-019 riscv_pkg SHALL hold XLEN, the NOP constant 32'h0000_0013 and typedef fetch_entry_t {pc, instr}.
REQ-020 Queue storage SHALL be sub-module fifo_sync (parameter DEPTH, entry type fetch_entry_t, flush input, count output).

Verification
REQ-021 Reset, 1-cycle-latency memory, ready=1 -> addresses 8000_0000, _0004, _0008...; instr_valid_o from cycle 3 onward, pc_o in order.
REQ-022 ready=0 for 10 cycles, DEPTH=4, MAX_OUTST=2 -> exactly 4 grants, then imem_req_o = 0; release -> 4 entries popped in PC order.
REQ-023 Redirect to 8000_0102 with 2 outstanding -> next addr 8000_0100; both old responses dropped; first valid pc_o = 8000_0100.
REQ-024 gnt held low 3 cycles -> imem_addr_o stable; redirect during wait -> request withdrawn, new address next cycle.
REQ-025 Redirect coincident with rvalid and pop -> that response dropped, pop suppressed, queue empty next cycle.
REQ-026 FETCH_QUEUE_PERF_EN defined, memory latency 5, ready=1 -> perf_empty_cnt_o equals empty-cycle count computed by the bench model.
